// File: rtl/shift_pkg.sv
// shift_pkg: shared widths, shift op encoding and sequencer state enum
package shift_pkg;
  localparam int W = 16;
  localparam int AMT_W = 4;
  typedef enum logic [1:0] {
    SH_PASS = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } sh_op_e;
  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;
endpackage

// File: rtl/shifter.sv
// shifter: 16-bit single-step shifter; in operand, shift op (pass/LSL1/LSR1/ASR1), sout result
module shifter
  import shift_pkg::*;
(
  input  logic [W-1:0] in,
  input  logic [1:0]   shift,
  output logic [W-1:0] sout
);
  always_comb
    sout = shift == SH_LSL ? {in[W-2:0], 1'b0} :
           shift == SH_LSR ? {1'b0, in[W-1:1]} :
           shift == SH_ASR ? {in[W-1], in[W-1:1]} : in;
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-step shift via 1-bit shifter; clk/reset, start+in/op/amount capture, busy/done/result outputs
module shift_sequencer
  import shift_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [W-1:0]     in,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     result
);
  state_e state_q, state_d;
  sh_op_e op_q, op_d;
  logic [W-1:0] data_q, data_d, result_q, result_d, sout;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d, done_q, done_d;
  shifter u_shifter (.in(data_q), .shift(op_q), .sout(sout));
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    data_d = data_q;
    cnt_d = cnt_q;
    result_d = result_q;
    if (state_q == S_IDLE && start) begin
      data_d = in;
      op_d = sh_op_e'(op);
      cnt_d = amount;
      state_d = (amount == '0 || op == SH_PASS) ? S_DONE : S_SHIFT;
      result_d = (amount == '0 || op == SH_PASS) ? in : result_q;
    end else if (state_q == S_SHIFT) begin
      data_d = sout;
      cnt_d = cnt_q - AMT_W'(1);
      state_d = cnt_q == AMT_W'(1) ? S_DONE : S_SHIFT;
      result_d = cnt_q == AMT_W'(1) ? sout : result_q;
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end
    busy_d = state_d != S_IDLE;
    done_d = state_d == S_DONE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      op_q <= SH_PASS;
      data_q <= '0;
      cnt_q <= '0;
      result_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      data_q <= data_d;
      cnt_q <= cnt_d;
      result_q <= result_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  assign busy = busy_q;
  assign done = done_q;
  assign result = result_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed and random checks of shift_sequencer against an arithmetic reference
module tb_shift_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [15:0] din = '0;
  logic [1:0] opv = '0;
  logic [3:0] amt = '0;
  logic busy, done;
  logic [15:0] result;
  int checks = 0;
  int errors = 0;
  shift_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .in(din), .op(opv), .amount(amt),
    .busy(busy), .done(done), .result(result)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] model(input logic [15:0] i, input logic [1:0] o, input int a);
    case (o)
      2'b01: return i << a;
      2'b10: return i >> a;
      2'b11: return 16'($signed(i) >>> a);
      default: return i;
    endcase
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  // entered and left on a negedge with the DUT idle, so back-to-back calls start in the first idle cycle
  task automatic run_op(input logic [15:0] i, input logic [1:0] o, input logic [3:0] a,
                        input logic [15:0] exp, input bit inject);
    int lat, n;
    logic [15:0] prev;
    lat = (o == 2'b00 || a == 4'd0) ? 0 : int'(a);
    prev = result;
    start = 1'b1; din = i; opv = o; amt = a;
    @(negedge clk);
    start = 1'b0; din = 16'($urandom); opv = 2'($urandom); amt = 4'($urandom);
    n = 0;
    while (!done && n < 40) begin
      check("busy_during_shift", busy, 1);
      check("result_hold", result, prev);
      if (inject && n == 1) begin start = 1'b1; din = 16'hFFFF; opv = 2'b10; amt = 4'd2; end
      if (inject && n == 2) start = 1'b0;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("latency", n, lat);
    check("done_pulse", done, 1);
    check("busy_at_done", busy, 1);
    check("result", result, exp);
    @(negedge clk);
    check("done_cleared", done, 0);
    check("busy_cleared", busy, 0);
    check("result_kept", result, exp);
  endtask
  initial begin
    int seen;
    logic [15:0] ri;
    logic [1:0] ro;
    logic [3:0] ra;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 16'h0000);
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);
    run_op(16'h0001, 2'b01, 4'd4, 16'h0010, 0);
    run_op(16'h8000, 2'b11, 4'd3, 16'hF000, 0);
    run_op(16'h4000, 2'b11, 4'd3, 16'h0800, 0);
    run_op(16'h8000, 2'b10, 4'd15, 16'h0001, 0);
    run_op(16'hA5A5, 2'b01, 4'd0, 16'hA5A5, 0);
    run_op(16'hA5A5, 2'b00, 4'd7, 16'hA5A5, 0);
    run_op(16'h0003, 2'b01, 4'd5, 16'h0060, 1);
    run_op(16'h1234, 2'b10, 4'd4, 16'h0123, 0);
    start = 1'b1; din = 16'hFF00; opv = 2'b10; amt = 4'd8;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_result", result, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    check("no_activity_after_rst", seen, 0);
    run_op(16'h00F0, 2'b01, 4'd2, 16'h03C0, 0);
    repeat (40) begin
      ri = 16'($urandom);
      ro = 2'($urandom);
      ra = 4'($urandom);
      run_op(ri, ro, ra, model(ri, ro, int'(ra)),
             (ro != 2'b00 && ra >= 4'd3) ? bit'($urandom_range(0, 1)) : 1'b0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
